// File: rtl/vending_machine_fsm.sv
// Coin vending controller: price 3 units, registered dispense (x) and change (y) pulses.
// Optional VEND_STATS_EN adds vend_cnt/chg_cnt dispense and change counters.
module vending_machine_fsm (
   output logic       x,
   output logic       y,
   input  logic [1:0] coin,
   input  logic       reset,
   input  logic       clock
`ifdef VEND_STATS_EN
   ,
   output logic [7:0] vend_cnt,
   output logic [7:0] chg_cnt
`endif
);

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;

   localparam logic [1:0] C_NONE = 2'b00;
   localparam logic [1:0] C_ONE  = 2'b01;
   localparam logic [1:0] C_TWO  = 2'b10;

   logic [1:0] pre_st;
   logic [1:0] nxt_st;
   logic       nxt_x;
   logic       nxt_y;

   // State and output registers; reset discards credit with no refund
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_st <= S0;
         x      <= 1'b0;
         y      <= 1'b0;
      end else begin
         pre_st <= nxt_st;
         x      <= nxt_x;
         y      <= nxt_y;
      end
   end

   // Next credit state; invalid coin holds, unreachable 11 falls back to S0
   always_comb begin
      nxt_st = S0;
      case (pre_st)
         S0: begin
            case (coin)
               C_ONE:   nxt_st = S1;
               C_TWO:   nxt_st = S2;
               default: nxt_st = S0;
            endcase
         end
         S1: begin
            case (coin)
               C_ONE:   nxt_st = S2;
               C_TWO:   nxt_st = S0;
               default: nxt_st = S1;
            endcase
         end
         S2: begin
            case (coin)
               C_ONE:   nxt_st = S0;
               C_TWO:   nxt_st = S0;
               default: nxt_st = S2;
            endcase
         end
         default: nxt_st = S0;
      endcase
   end

   // Dispense when credit reaches 3, change when it reaches 4
   always_comb begin
      nxt_x = 1'b0;
      nxt_y = 1'b0;
      case (pre_st)
         S1: begin
            nxt_x = (coin == C_TWO);
         end
         S2: begin
            nxt_x = (coin == C_ONE) || (coin == C_TWO);
            nxt_y = (coin == C_TWO);
         end
         default: begin
            nxt_x = 1'b0;
            nxt_y = 1'b0;
         end
      endcase
   end

`ifdef VEND_STATS_EN
   // Count edges that set x and y; 8-bit counters wrap naturally
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vend_cnt <= 8'd0;
         chg_cnt  <= 8'd0;
      end else begin
         if (nxt_x) vend_cnt <= vend_cnt + 8'd1;
         if (nxt_y) chg_cnt  <= chg_cnt + 8'd1;
      end
   end
`endif

   logic unused_none;
   assign unused_none = (C_NONE == 2'b00);

endmodule

// File: tb/tb_vending_machine_fsm.sv
// Directed vector bench for vending_machine_fsm.
// Table of coin/expected-state records plus reset corner sequences.
module tb_vending_machine_fsm;

   logic       clock;
   logic       reset;
   logic [1:0] coin;
   logic       x;
   logic       y;
`ifdef VEND_STATS_EN
   logic [7:0] vend_cnt;
   logic [7:0] chg_cnt;
`endif

   int n_pass;
   int n_total;

   typedef struct {
      logic [1:0] coin;
      logic [1:0] st;
      logic       x;
      logic       y;
   } vec_t;

   vec_t vecs[23];

   vending_machine_fsm dut (
      .x     (x),
      .y     (y),
      .coin  (coin),
      .reset (reset),
`ifdef VEND_STATS_EN
      .vend_cnt (vend_cnt),
      .chg_cnt  (chg_cnt),
`endif
      .clock (clock)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_all(input string name, input logic [1:0] st,
                          input logic ex, input logic ey);
      chk({name, ".st"}, {6'd0, dut.pre_st}, {6'd0, st});
      chk({name, ".x"}, {7'd0, x}, {7'd0, ex});
      chk({name, ".y"}, {7'd0, y}, {7'd0, ey});
   endtask

   task automatic step(input logic [1:0] c);
      @(negedge clock);
      coin = c;
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0};
      vecs[1]  = '{2'b11, 2'b00, 1'b0, 1'b0};
      vecs[2]  = '{2'b01, 2'b01, 1'b0, 1'b0};
      vecs[3]  = '{2'b11, 2'b01, 1'b0, 1'b0};
      vecs[4]  = '{2'b10, 2'b00, 1'b1, 1'b0};
      vecs[5]  = '{2'b10, 2'b10, 1'b0, 1'b0};
      vecs[6]  = '{2'b11, 2'b10, 1'b0, 1'b0};
      vecs[7]  = '{2'b10, 2'b00, 1'b1, 1'b1};
      vecs[8]  = '{2'b00, 2'b00, 1'b0, 1'b0};
      vecs[9]  = '{2'b10, 2'b10, 1'b0, 1'b0};
      vecs[10] = '{2'b01, 2'b00, 1'b1, 1'b0};
      vecs[11] = '{2'b11, 2'b00, 1'b0, 1'b0};
      vecs[12] = '{2'b01, 2'b01, 1'b0, 1'b0};
      vecs[13] = '{2'b10, 2'b00, 1'b1, 1'b0};
      vecs[14] = '{2'b01, 2'b01, 1'b0, 1'b0};
      vecs[15] = '{2'b01, 2'b10, 1'b0, 1'b0};
      vecs[16] = '{2'b01, 2'b00, 1'b1, 1'b0};
      vecs[17] = '{2'b10, 2'b10, 1'b0, 1'b0};
      vecs[18] = '{2'b01, 2'b00, 1'b1, 1'b0};
      vecs[19] = '{2'b11, 2'b00, 1'b0, 1'b0};
      vecs[20] = '{2'b01, 2'b01, 1'b0, 1'b0};
      vecs[21] = '{2'b10, 2'b00, 1'b1, 1'b0};
      vecs[22] = '{2'b10, 2'b10, 1'b0, 1'b0};

      // Reset held with a live coin: state must stay cleared
      reset = 1'b1;
      coin  = 2'b01;
      @(posedge clock);
      #1;
      chk_all("rst_hold", 2'b00, 1'b0, 1'b0);
      @(negedge clock);
      coin  = 2'b00;
      reset = 1'b0;
      step(2'b00);
      chk_all("rst_rel", 2'b00, 1'b0, 1'b0);
`ifdef VEND_STATS_EN
      chk("cnt_rst_v", vend_cnt, 8'd0);
      chk("cnt_rst_c", chg_cnt, 8'd0);
`endif

      for (int i = 0; i < 23; i++) begin
         step(vecs[i].coin);
         chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].x, vecs[i].y);
      end
`ifdef VEND_STATS_EN
      chk("cnt_tbl_v", vend_cnt, 8'd7);
      chk("cnt_tbl_c", chg_cnt, 8'd1);
`endif

      // Async reset while in S2, between clock edges
      step(2'b00);
      chk_all("pre_arst", 2'b10, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_all("arst_s2", 2'b00, 1'b0, 1'b0);
`ifdef VEND_STATS_EN
      chk("cnt_arst_v", vend_cnt, 8'd0);
`endif
      @(negedge clock);
      reset = 1'b0;

      // Three vends after reset, one with change
      step(2'b01);
      step(2'b10);
      chk_all("v1", 2'b00, 1'b1, 1'b0);
      step(2'b10);
      step(2'b10);
      chk_all("v2", 2'b00, 1'b1, 1'b1);
      step(2'b10);
      step(2'b01);
      chk_all("v3", 2'b00, 1'b1, 1'b0);
      step(2'b00);
      chk_all("v3_drop", 2'b00, 1'b0, 1'b0);
`ifdef VEND_STATS_EN
      chk("cnt3_v", vend_cnt, 8'd3);
      chk("cnt3_c", chg_cnt, 8'd1);
`endif

      // Async reset while x/y pulses are high clears them at once
      step(2'b10);
      step(2'b10);
      chk_all("pre_arst2", 2'b00, 1'b1, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("arst_pulse", 2'b00, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      coin  = 2'b00;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
